tx_serial_param: RTL
====================

TX_SERIAL_PARAM -- requirements
Module: tx_serial_param

Interface
REQ-001 Parameter DATA_BITS, default 7, data bits per frame; legal range 5..8.
REQ-002 Parameter PARITY, default 1, parity mode: 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, default 2, stop bits per frame; legal values 1 or 2.
REQ-004 Parameter CLK_DIV, default 434, clock cycles per bit; legal range 2..8191.
REQ-005 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..16.
REQ-006 clock  in  1  single system clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 partida  in  1  write strobe; one frame is enqueued per cycle in which it is high.
REQ-009 dados  in  DATA_BITS  character to enqueue, sampled with partida.
REQ-010 saida_serial  out  1  serial line; idle high.
REQ-011 pronto  out  1  one-cycle pulse after the last stop bit of each frame.
REQ-012 ocupado  out  1  high while the FSM is not in IDLE.
REQ-013 fifo_cheia / fifo_vazia  out  1 each  FIFO full / empty flags.
REQ-014 erro_overflow  out  1  one-cycle pulse when a write is dropped.
REQ-015 db_tick  out  1  bit-period tick, for debug.
REQ-016 db_estado  out  4  FSM state encoding, for debug.

Function
REQ-017 Frame on the line: start bit 0, then data LSB first, then the parity bit if PARITY!=0, then STOP_BITS stop bits of 1.
REQ-018 Even parity bit = XOR of the data bits; odd parity bit = its inverse.
REQ-019 Each bit is held for exactly CLK_DIV cycles; the bit counter is zeroed in LOAD, so the first bit is not shortened.
REQ-020 FSM states and encoding: IDLE=0, LOAD=1, START=2, DATA=3, PARITY=4, STOP=5, DONE=6.
REQ-021 FSM transitions:
- IDLE->LOAD when the FIFO is non-empty;
- LOAD->START after one cycle;
- START->DATA on tick;
- DATA->PARITY, or DATA->STOP if PARITY=0, on the tick following data bit DATA_BITS-1;
- PARITY->STOP on tick;
- STOP->DONE on the tick ending the last stop bit;
- DONE->LOAD if the FIFO is non-empty, else DONE->IDLE.
REQ-022 LOAD pops the FIFO head into the shift register and computes the parity bit.
REQ-023 Latency: partida sampled at edge N with the FSM in IDLE and the FIFO empty gives saida_serial=0 from edge N+2.
REQ-024 Back-to-back frames: the line stays high for exactly 2 cycles (DONE, LOAD) between the end of the last stop bit and the next start bit.
REQ-025 A write while fifo_cheia=1 is dropped, even if a pop occurs in the same cycle, and erro_overflow pulses in the next cycle.
REQ-026 A write and a pop in the same cycle on a non-full FIFO leave the occupancy unchanged.
REQ-027 Pointers wrap modulo FIFO_DEPTH, with a separate count to distinguish full from empty.
REQ-028 Changes on dados or partida during a frame never alter the frame in progress.

Reset
REQ-029 reset, sampled high at a rising edge, forces on the next cycle:
- FSM=IDLE, saida_serial=1;
- pronto=0, ocupado=0, erro_overflow=0;
- fifo_vazia=1, fifo_cheia=0, FIFO contents discarded;
- bit and tick counters=0.
REQ-030 Reset mid-frame aborts the frame immediately; no partial stop bits and no pronto pulse are emitted.
REQ-031 reset takes priority over partida in the same cycle.

Structure
REQ-032 Package tx_serial_pkg holds the state encodings and the PARITY_NONE/EVEN/ODD constants.
REQ-033 The FIFO is a sub-module fifo_sync (parameters WIDTH, DEPTH) with synchronous reset; the FSM, shift register and baud counter stay in tx_serial_param.

Verification
REQ-034 Defaults with CLK_DIV=4: write 0x41 -> line 0,1,0,0,0,0,0,1,0,1,1, each bit 4 cycles; pronto pulses once, 44 cycles after the start edge.
REQ-035 DATA_BITS=8, PARITY=2, STOP_BITS=1: write 0xFF -> line 0, 1 x8, 1 (parity), 1 (stop); 11 bits total.
REQ-036 Writes of 0x11..0x16 on 6 consecutive cycles, DEPTH 4 -> fifo_cheia after the 5th; the 6th is dropped with one erro_overflow pulse; exactly 5 frames are sent, in order, each separated by a 2-cycle high gap.
REQ-037 Assert reset during data bit 3 -> saida_serial=1 and db_estado=0 next cycle, fifo_vazia=1, no pronto; a later write transmits normally.
REQ-038 PARITY=0, STOP_BITS=1, DATA_BITS=5: write 0x15 -> line 0,1,0,1,0,1,1; frame of 7 bits.
REQ-039 Toggle dados and partida while the FIFO is full and a frame is in flight -> the frame on the line is unchanged.

Source files
------------

// File: rtl/tx_serial_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tx_serial_pkg
// Purpose  : Shared definitions for the parameterised serial transmitter:
//            FSM state encoding (also visible on db_estado), parity mode
//            constants and the parity helper used when a character is loaded.
// Revision : 1.0 - initial release
// ============================================================================
package tx_serial_pkg;

    // Encoding is exported on the debug port, so the values are fixed.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_START  = 4'd2,
        ST_DATA   = 4'd3,
        ST_PARITY = 4'd4,
        ST_STOP   = 4'd5,
        ST_DONE   = 4'd6
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Unused upper bits must be zero, so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_sync
// Purpose  : Single-clock FIFO with first-word-fall-through read data.
//            A write while full is dropped (even with a pop in the same
//            cycle) and flagged on o_overflow one cycle later.
// Ports    : clk, rst (sync, active high)
//            i_wr_en/i_wr_data  push side
//            i_rd_en/o_rd_data  pop side (o_rd_data is the current head)
//            o_full, o_empty, o_overflow
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // The count, not the pointers, separates full from empty.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // Fullness is judged before any same-cycle pop.
    assign w_push  = i_wr_en & ~w_full & ~rst;
    assign w_pop   = i_rd_en & ~w_empty;

    // Storage has no reset; resetting the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Pointer width equals log2(DEPTH), so wrap is implicit.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow <= i_wr_en & w_full;
        end
    end

    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/tx_serial_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tx_serial_param
// Purpose  : Parameterised asynchronous serial transmitter with a transmit
//            FIFO. Frame: start(0), data LSB first, optional parity,
//            STOP_BITS stop bits(1). Every bit lasts CLK_DIV clocks.
// Ports    : clock, reset (sync, active high)
//            partida/dados     enqueue strobe and character
//            saida_serial      serial line, idle high (registered)
//            pronto            1-cycle pulse after the last stop bit
//            ocupado           FSM not idle
//            fifo_cheia/vazia  FIFO full/empty, erro_overflow dropped write
//            db_tick, db_estado  debug: bit tick and FSM state
// Revision : 1.0 - initial release
// ============================================================================
module tx_serial_param
    import tx_serial_pkg::*;
#(
    parameter int DATA_BITS  = 7,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 2,
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 partida,
    input  logic [DATA_BITS-1:0] dados,
    output logic                 saida_serial,
    output logic                 pronto,
    output logic                 ocupado,
    output logic                 fifo_cheia,
    output logic                 fifo_vazia,
    output logic                 erro_overflow,
    output logic                 db_tick,
    output logic [3:0]           db_estado
);

    localparam int             CNT_W       = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] c_div_last  = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]     c_data_last = 3'(DATA_BITS - 1);
    localparam logic [2:0]     c_stop_last = 3'(STOP_BITS - 1);

    tx_state_t            r_state;
    tx_state_t            w_state_next;
    logic [CNT_W-1:0]     r_tick_cnt;
    logic [CNT_W-1:0]     w_tick_cnt_next;
    logic [2:0]           r_bit_cnt;
    logic [2:0]           w_bit_cnt_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_par;
    logic                 w_par_next;
    logic                 r_serial;
    logic                 w_serial_next;
    logic                 r_pronto;
    logic                 r_ocupado;

    logic                 w_in_bit;
    logic                 w_tick;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_fifo_dout;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_fifo_ovf;

    fifo_sync #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clock),
        .rst        (reset),
        .i_wr_en    (partida),
        .i_wr_data  (dados),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_fifo_dout),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_overflow (w_fifo_ovf)
    );

    // The baud counter only runs while a bit is on the line.
    assign w_in_bit = (r_state == ST_START) || (r_state == ST_DATA) ||
                      (r_state == ST_PARITY) || (r_state == ST_STOP);
    assign w_tick   = w_in_bit && (r_tick_cnt == c_div_last);

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_par_next      = r_par;
        w_pop           = 1'b0;
        w_tick_cnt_next = '0;

        if (w_in_bit && !w_tick) begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Character and its parity are captured here, so later
                // FIFO traffic cannot disturb the frame in progress.
                w_pop          = 1'b1;
                w_shift_next   = w_fifo_dout;
                w_par_next     = parity_bit(8'(w_fifo_dout), PARITY);
                w_bit_cnt_next = '0;
                w_state_next   = ST_START;
            end
            ST_START: begin
                if (w_tick) begin
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == c_data_last) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                        w_shift_next   = r_shift >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                // The bit counter is reused to count stop bits.
                if (w_tick) begin
                    if (r_bit_cnt == c_stop_last) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = ST_DONE;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = w_fifo_empty ? ST_IDLE : ST_LOAD;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Line level is decoded from the next state so the output can be
        // registered without adding a cycle of latency.
        w_serial_next = 1'b1;
        case (w_state_next)
            ST_START:  w_serial_next = 1'b0;
            ST_DATA:   w_serial_next = w_shift_next[0];
            ST_PARITY: w_serial_next = w_par_next;
            default:   w_serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_serial   <= 1'b1;
            r_pronto   <= 1'b0;
            r_ocupado  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_par      <= w_par_next;
            r_serial   <= w_serial_next;
            r_pronto   <= (w_state_next == ST_DONE);
            r_ocupado  <= (w_state_next != ST_IDLE);
        end
    end

    assign saida_serial  = r_serial;
    assign pronto        = r_pronto;
    assign ocupado       = r_ocupado;
    assign fifo_cheia    = w_fifo_full;
    assign fifo_vazia    = w_fifo_empty;
    assign erro_overflow = w_fifo_ovf;
    assign db_tick       = w_tick;
    assign db_estado     = r_state;

endmodule
`default_nettype wire
